// File: rtl/cordic_pkg.sv
// Shared types and constants for the CORDIC iteration stages.
package cordic_pkg;

  localparam int unsigned WIDTH = 16;

  localparam logic signed [WIDTH-1:0] SAT_MAX = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic signed [WIDTH-1:0] SAT_MIN = {1'b1, {(WIDTH-1){1'b0}}};

  typedef logic signed [WIDTH-1:0] sample_t;

  typedef enum logic {
    CCW = 1'b0,
    CW  = 1'b1
  } dir_e;

endpackage

// File: rtl/cordic_jln2_iter_if.sv
// Vector/control bundle for one CORDIC micro-rotation stage.
interface cordic_jln2_iter_if #(
  parameter int unsigned WIDTH = 16
);
  logic                    in_valid;
  logic                    c2;
  logic                    c1;
  logic                    c0;
  logic signed [WIDTH-1:0] X;
  logic signed [WIDTH-1:0] Y;
  logic                    out_valid;
  logic signed [WIDTH-1:0] Xnew;
  logic signed [WIDTH-1:0] Ynew;

  modport master (
    output in_valid, c2, c1, c0, X, Y,
    input  out_valid, Xnew, Ynew
  );

  modport slave (
    input  in_valid, c2, c1, c0, X, Y,
    output out_valid, Xnew, Ynew
  );
endinterface

// File: rtl/cordic_sat_addsub.sv
// Signed add/subtract in WIDTH+1 bits, clamped back to WIDTH bits.
module cordic_sat_addsub #(
  parameter int unsigned WIDTH = 16
) (
  input  logic signed [WIDTH-1:0] a,
  input  logic signed [WIDTH-1:0] b,
  input  logic                    sub,
  output logic signed [WIDTH-1:0] y
);

  localparam logic signed [WIDTH-1:0] SatMax = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic signed [WIDTH-1:0] SatMin = {1'b1, {(WIDTH-1){1'b0}}};

  logic signed [WIDTH:0] ae;
  logic signed [WIDTH:0] be;
  logic signed [WIDTH:0] sum;

  always_comb begin
    ae  = {a[WIDTH-1], a};
    be  = {b[WIDTH-1], b};
    sum = sub ? (ae - be) : (ae + be);
    // The two top bits disagree only when the result left the WIDTH-bit range.
    if (sum[WIDTH] != sum[WIDTH-1]) begin
      y = sum[WIDTH] ? SatMin : SatMax;
    end else begin
      y = sum[WIDTH-1:0];
    end
  end

endmodule

// File: rtl/cordic_jln2_iter.sv
// Registered Enhanced-CORDIC micro-rotation at jump level SHIFT (shift SHIFT or SHIFT+1).
module cordic_jln2_iter #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned SHIFT = 2
) (
  input logic              clk,
  input logic              rst_n,
  cordic_jln2_iter_if.slave bus
);
  import cordic_pkg::*;

  logic signed [WIDTH-1:0] xs;
  logic signed [WIDTH-1:0] ys;
  logic signed [WIDTH-1:0] x_b;
  logic signed [WIDTH-1:0] y_b;
  logic signed [WIDTH-1:0] x_res;
  logic signed [WIDTH-1:0] y_res;
  logic                    x_sub;
  logic                    y_sub;
  dir_e                    dir;

  logic                    out_valid_q;
  logic signed [WIDTH-1:0] xnew_q;
  logic signed [WIDTH-1:0] ynew_q;

  always_comb begin
    dir = dir_e'(bus.c1);
    xs  = bus.c2 ? (bus.X >>> (SHIFT + 1)) : (bus.X >>> SHIFT);
    ys  = bus.c2 ? (bus.Y >>> (SHIFT + 1)) : (bus.Y >>> SHIFT);
    // Pass-through is an add of zero, which can never saturate.
    x_b   = bus.c0 ? ys : '0;
    y_b   = bus.c0 ? xs : '0;
    x_sub = bus.c0 && (dir == CCW);
    y_sub = bus.c0 && (dir == CW);
  end

  cordic_sat_addsub #(
    .WIDTH (WIDTH)
  ) u_x_addsub (
    .a   (bus.X),
    .b   (x_b),
    .sub (x_sub),
    .y   (x_res)
  );

  cordic_sat_addsub #(
    .WIDTH (WIDTH)
  ) u_y_addsub (
    .a   (bus.Y),
    .b   (y_b),
    .sub (y_sub),
    .y   (y_res)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      xnew_q      <= '0;
      ynew_q      <= '0;
    end else begin
      out_valid_q <= bus.in_valid;
      if (bus.in_valid) begin
        xnew_q <= x_res;
        ynew_q <= y_res;
      end
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.Xnew      = xnew_q;
  assign bus.Ynew      = ynew_q;

endmodule

// File: tb/tb_cordic_jln2_iter.sv
// Directed and random checks of cordic_jln2_iter against an integer reference model.
module tb_cordic_jln2_iter;

  logic clk;
  logic rst_n;
  int   nvec;
  int   nerr;
  int   exp_x;
  int   exp_y;

  cordic_jln2_iter_if #(.WIDTH(16)) bus ();

  cordic_jln2_iter #(
    .WIDTH (16),
    .SHIFT (2)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int sat16(input int v);
    if (v > 32767) return 32767;
    if (v < -32768) return -32768;
    return v;
  endfunction

  function automatic void model(input bit c2, input bit c1, input bit c0, input int x,
                                input int y, output int xn, output int yn);
    int s;
    int xs;
    int ys;
    s  = 2 + int'(c2);
    xs = x >>> s;
    ys = y >>> s;
    if (!c0) begin
      xn = x;
      yn = y;
    end else if (!c1) begin
      xn = sat16(x - ys);
      yn = sat16(y + xs);
    end else begin
      xn = sat16(x + ys);
      yn = sat16(y - xs);
    end
  endfunction

  task automatic check(input string tag, input logic signed [31:0] obs,
                       input logic signed [31:0] expv);
    nvec++;
    assert (obs === expv)
    else begin
      nerr++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  task automatic check_out(input string tag, input logic ov, input int xe, input int ye);
    check({tag, ".valid"}, 32'(bus.out_valid), 32'(ov));
    check({tag, ".x"}, 32'(bus.Xnew), xe);
    check({tag, ".y"}, 32'(bus.Ynew), ye);
  endtask

  task automatic drive(input bit v, input bit c2, input bit c1, input bit c0, input int x,
                       input int y);
    bus.in_valid = v;
    bus.c2       = c2;
    bus.c1       = c1;
    bus.c0       = c0;
    bus.X        = 16'(x);
    bus.Y        = 16'(y);
  endtask

  // Drive at negedge, sample 1 time unit after the capturing edge.
  task automatic step(input string tag, input bit c2, input bit c1, input bit c0, input int x,
                      input int y, input int xe, input int ye);
    int mx;
    int my;
    @(negedge clk);
    drive(1'b1, c2, c1, c0, x, y);
    model(c2, c1, c0, x, y, mx, my);
    @(posedge clk);
    #1;
    check_out(tag, 1'b1, xe, ye);
    check({tag, ".model_x"}, 32'(bus.Xnew), mx);
    check({tag, ".model_y"}, 32'(bus.Ynew), my);
    exp_x = xe;
    exp_y = ye;
  endtask

  initial begin
    logic [15:0] rx;
    logic [15:0] ry;
    bit          rv;
    bit          r2;
    bit          r1;
    bit          r0;
    int          xi;
    int          yi;
    nvec  = 0;
    nerr  = 0;
    exp_x = 0;
    exp_y = 0;
    rst_n = 1'b1;
    drive(1'b1, 1'($urandom), 1'($urandom), 1'($urandom), int'($urandom), int'($urandom));

    // Asynchronous reset: no clock edge between assertion and check.
    #3;
    rst_n = 1'b0;
    #1;
    check_out("reset_async", 1'b0, 0, 0);
    @(posedge clk);
    #1;
    check_out("reset_held", 1'b0, 0, 0);
    @(negedge clk);
    rst_n = 1'b1;

    step("pass", 1'b1, 1'b1, 1'b0, 1024, 2048, 1024, 2048);
    step("ccw_s2", 1'b0, 1'b0, 1'b1, 1024, 2048, 512, 2304);
    step("ccw_s3", 1'b1, 1'b0, 1'b1, 1024, 2048, 768, 2176);
    step("cw_s2", 1'b0, 1'b1, 1'b1, 1024, 2048, 1536, 1792);
    step("ccw_neg", 1'b0, 1'b0, 1'b1, -1024, 3, -1024, -253);
    step("sat_xmax", 1'b0, 1'b0, 1'b1, 32767, -32768, 32767, -24577);
    step("sat_ymin", 1'b0, 1'b0, 1'b1, -32768, -32768, -24576, -32768);

    // Bubble: outputs hold, valid drops.
    @(negedge clk);
    drive(1'b0, 1'b0, 1'b1, 1'b1, 100, 200);
    @(posedge clk);
    #1;
    check_out("bubble1", 1'b0, exp_x, exp_y);
    @(posedge clk);
    #1;
    check_out("bubble2", 1'b0, exp_x, exp_y);

    // Reset pulse between two valid inputs.
    step("pre_rst", 1'b0, 1'b1, 1'b1, 1024, 2048, 1536, 1792);
    rst_n = 1'b0;
    #1;
    check_out("rst_mid", 1'b0, 0, 0);
    rst_n = 1'b1;
    step("post_rst", 1'b1, 1'b0, 1'b1, 1024, 2048, 768, 2176);

    // In-flight sample discarded when reset spans its capture edge.
    @(negedge clk);
    drive(1'b1, 1'b0, 1'b0, 1'b1, 4000, 4000);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    check_out("rst_inflight", 1'b0, 0, 0);
    @(negedge clk);
    rst_n = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 1'b1, 4000, 4000);
    @(posedge clk);
    #1;
    check_out("rst_release_idle", 1'b0, 0, 0);
    exp_x = 0;
    exp_y = 0;

    // Random stream, including bubbles and values near the rails.
    for (int i = 0; i < 60; i++) begin
      rv = ($urandom_range(0, 3) != 0);
      r2 = 1'($urandom);
      r1 = 1'($urandom);
      r0 = ($urandom_range(0, 4) != 0);
      rx = 16'($urandom);
      ry = 16'($urandom);
      if ($urandom_range(0, 3) == 0) rx = {rx[15], {15{~rx[15]}}};
      if ($urandom_range(0, 3) == 0) ry = {ry[15], {15{~ry[15]}}};
      xi = int'($signed(rx));
      yi = int'($signed(ry));
      @(negedge clk);
      drive(rv, r2, r1, r0, xi, yi);
      if (rv) model(r2, r1, r0, xi, yi, exp_x, exp_y);
      @(posedge clk);
      #1;
      check_out($sformatf("rand%0d", i), rv, exp_x, exp_y);
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/cordic_jln2_iter.md
Name: cordic_jln2_iter

Overview:
- Single registered micro-rotation stage of the Enhanced-CORDIC datapath, at jump level 2.
- Takes a signed (X, Y) vector and a 3-bit control code (c2, c1, c0). Returns the rotated vector one clock later.
- Cascaded with other iteration stages; the control bits come from the upstream angle-decision logic.

Parameters:
- WIDTH, 16: data width of X/Y/Xnew/Ynew, signed two's complement.
- SHIFT, 2: base shift amount (jump level) of this stage.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  qualifies c2/c1/c0/X/Y this cycle.
- c2  input  1  shift select: 0 gives SHIFT, 1 gives SHIFT+1.
- c1  input  1  direction: 0 counter-clockwise, 1 clockwise.
- c0  input  1  rotate enable: 0 passes through, 1 rotates.
- X  input  WIDTH  signed x component.
- Y  input  WIDTH  signed y component.
- out_valid  output  1  Xnew/Ynew hold a new result.
- Xnew  output  WIDTH  signed rotated x.
- Ynew  output  WIDTH  signed rotated y.

Behaviour:
- Reset: asserting rst_n low immediately forces out_valid=0, Xnew=0, Ynew=0. This is asynchronous and holds regardless of clk. Release is used synchronously by the next rising edge.
- Latency: exactly 1 cycle. Inputs sampled at edge k with in_valid=1 appear at edge k with out_valid=1.
- in_valid=0 at an edge:
  - out_valid goes to 0.
  - Xnew/Ynew keep their previous values; no pipeline bubble data is written.
- No backpressure; a new vector is accepted every cycle.
- Effective shift: s = SHIFT + c2.
- Shifted terms use arithmetic right shifts (sign-extending, truncating toward minus infinity): xs = X >>> s, ys = Y >>> s.
- c0=0: Xnew=X, Ynew=Y. c1 and c2 are ignored.
- c0=1, c1=0: Xnew = X - ys, Ynew = Y + xs.
- c0=1, c1=1: Xnew = X + ys, Ynew = Y - xs.
- Arithmetic width:
  - Sums are computed in WIDTH+1 bits.
  - The result saturates to the range [-2^(WIDTH-1), 2^(WIDTH-1)-1], i.e. [-32768, 32767] at default width.
  - Saturation is applied independently per component. There is no wrap-around.
- No CORDIC gain compensation in this stage; that is done downstream.
- Reset asserted mid-stream: the in-flight result is discarded. The first valid output after release comes from the first in_valid=1 sample after release.
- Combinational path: inputs, then shift, then add/sub, then saturate, then output register. Nothing else sits in the path.

Decomposition:
- Shared package cordic_pkg holds:
  - the WIDTH default;
  - the constants SAT_MAX and SAT_MIN;
  - a typedef for a signed WIDTH-bit sample;
  - an enum for the direction (CCW=0, CW=1).
- One natural sub-module, cordic_sat_addsub:
  - inputs a, b and sub;
  - outputs the saturated WIDTH-bit result;
  - instantiated twice, once for X and once for Y.

Test Plan:
- Reset: drive rst_n=0 with in_valid=1 and random inputs, no clock edge → out_valid=0, Xnew=0, Ynew=0 immediately.
- Pass-through: c0=0, c1=1, c2=1, X=1024, Y=2048 → one cycle later Xnew=1024, Ynew=2048, out_valid=1.
- Counter-clockwise rotation:
  - c2=0, c1=0, c0=1, X=1024, Y=2048 → Xnew=512, Ynew=2304.
  - Same vector with c2=1 → Xnew=768, Ynew=2176.
- Clockwise and negative:
  - c2=0, c1=1, c0=1, X=1024, Y=2048 → Xnew=1536, Ynew=1792.
  - c2=0, c1=0, c0=1, X=-1024, Y=3 → Xnew=-1024, Ynew=-253 (Y>>>2=0).
- Saturation:
  - c2=0, c1=0, c0=1, X=32767, Y=-32768 → Xnew=32767 (saturated), Ynew=-24577.
  - Same control, X=-32768, Y=-32768 → Xnew=-24576, Ynew=-32768 (saturated).
- Valid and reset mid-stream:
  - Back-to-back valid vectors, then in_valid=0 → outputs hold their last value and out_valid=0.
  - Pulse rst_n low between two valid inputs → outputs clear, and the next valid result is correct after one cycle.
